// File: rtl/seq_ula_c_pkg.sv
// Shared types and constants for the constant-load sequencer feeding ULA_C.
package seq_ula_c_pkg;

  typedef enum logic [1:0] {
    OP_ILL = 2'b00,
    OP_LDL = 2'b01,
    OP_LCL = 2'b10,
    OP_LCH = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXEC,
    WRITE,
    ERR
  } state_t;

  localparam logic [1:0] TIPO_NONE = 2'b00;
  localparam logic [1:0] TIPO_PASS = 2'b01;
  localparam logic [1:0] TIPO_BYTE = 2'b11;

endpackage

// File: rtl/seq_ula_c_flags.sv
// Zero/sign flag register, loaded from the written-back word when enabled.
module seq_ula_c_flags #(
  parameter int unsigned BITS_PALAVRA = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [BITS_PALAVRA-1:0] value,
  output logic                    flag_z,
  output logic                    flag_s
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_s <= 1'b0;
    end else if (en) begin
      flag_z <= (value == '0);
      flag_s <= value[BITS_PALAVRA-1];
    end
  end

endmodule

// File: rtl/seq_ula_c.sv
// Multi-cycle sequencer for loadlit/lcl/lch: reads rd when merging, drives ULA_C,
// registers the result, writes it back and updates Z/S.
module seq_ula_c
  import seq_ula_c_pkg::*;
#(
  parameter int unsigned BITS_PALAVRA = 16,
  parameter int unsigned REG_ADDR_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [REG_ADDR_W-1:0]   req_rd,
  input  logic [BITS_PALAVRA-1:0] req_imm,
  input  logic                    flush,
  output logic [REG_ADDR_W-1:0]   rf_raddr,
  input  logic [BITS_PALAVRA-1:0] rf_rdata,
  output logic [1:0]              ula_tipo,
  output logic                    ula_R,
  output logic [BITS_PALAVRA-1:0] ula_constante,
  output logic [BITS_PALAVRA-1:0] ula_dado,
  input  logic [BITS_PALAVRA-1:0] ula_result,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_waddr,
  output logic [BITS_PALAVRA-1:0] rf_wdata,
  output logic                    done,
  output logic                    err,
  output logic                    flag_z,
  output logic                    flag_s
);

  localparam int unsigned BYTE = BITS_PALAVRA / 2;

  state_t                  state, state_next;
  op_t                     op_q;
  logic [REG_ADDR_W-1:0]   rd_q;
  logic [BITS_PALAVRA-1:0] imm_q;
  logic [BITS_PALAVRA-1:0] dado_q;
  logic [BITS_PALAVRA-1:0] wdata_q;
  logic                    accept;

  // Flush blocks acceptance in the same cycle, so ready drops with it.
  assign req_ready = (state == IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_next = state;
    ula_tipo   = TIPO_NONE;
    ula_R      = 1'b0;
    rf_we      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op_t'(req_op))
            OP_LDL:         state_next = EXEC;
            OP_LCL, OP_LCH: state_next = READ;
            default:        state_next = ERR;
          endcase
        end
      end
      READ: state_next = EXEC;
      EXEC: begin
        state_next = WRITE;
        ula_tipo   = (op_q == OP_LDL) ? TIPO_PASS : TIPO_BYTE;
        ula_R      = (op_q == OP_LCL);
      end
      WRITE: begin
        state_next = IDLE;
        rf_we      = !flush;
        done       = !flush;
      end
      ERR: begin
        state_next = IDLE;
        err        = !flush;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= OP_ILL;
      rd_q    <= '0;
      imm_q   <= '0;
      dado_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q  <= op_t'(req_op);
        rd_q  <= req_rd;
        imm_q <= req_imm;
      end
      if (state == READ) dado_q <= rf_rdata;
      if (state == EXEC) wdata_q <= ula_result;
    end
  end

  // Operands come straight from latched registers, so they hold outside EXEC.
  assign ula_constante = (op_q == OP_LDL) ? imm_q : {{BYTE{1'b0}}, imm_q[BYTE-1:0]};
  assign ula_dado      = dado_q;
  assign rf_raddr      = rd_q;
  assign rf_waddr      = rd_q;
  assign rf_wdata      = wdata_q;

  seq_ula_c_flags #(
    .BITS_PALAVRA(BITS_PALAVRA)
  ) u_flags (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (rf_we),
    .value  (wdata_q),
    .flag_z (flag_z),
    .flag_s (flag_s)
  );

endmodule

// File: tb/tb_seq_ula_c.sv
// Bench for seq_ula_c: register file and ULA_C models around the DUT, transaction-level reference.
module tb_seq_ula_c;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [3:0]  req_rd = '0;
  logic [15:0] req_imm = '0;
  logic        flush = 1'b0;
  logic [3:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic [1:0]  ula_tipo;
  logic        ula_R;
  logic [15:0] ula_constante;
  logic [15:0] ula_dado;
  logic [15:0] ula_result;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        done;
  logic        err;
  logic        flag_z;
  logic        flag_s;

  always #5 clk = ~clk;

  seq_ula_c #(
    .BITS_PALAVRA(16),
    .REG_ADDR_W  (4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_imm(req_imm), .flush(flush),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .ula_tipo(ula_tipo), .ula_R(ula_R),
    .ula_constante(ula_constante), .ula_dado(ula_dado), .ula_result(ula_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .done(done), .err(err),
    .flag_z(flag_z), .flag_s(flag_s)
  );

  // Environment: register file written by the DUT, and the ULA_C datapath.
  logic [15:0] mem [16];
  int          we_count = 0;
  assign rf_rdata = mem[rf_raddr];

  always @(posedge clk) begin
    if (rf_we) begin
      mem[rf_waddr] <= rf_wdata;
      we_count      <= we_count + 1;
    end
  end

  always_comb begin
    ula_result = '0;
    case (ula_tipo)
      2'b01: ula_result = ula_constante;
      2'b11: ula_result = ula_R ? {ula_dado[15:8], ula_constante[7:0]}
                                : {ula_constante[7:0], ula_dado[7:0]};
      default: ula_result = '0;
    endcase
  end

  // Reference: instruction-level model with a cycles-to-write countdown.
  logic [15:0] ref_mem [16];
  int          m_cnt = 0;
  bit          m_err = 0;
  logic [3:0]  m_addr = '0;
  logic [15:0] m_val = '0;
  bit          m_z = 0, m_s = 0;
  bit          m_accepted = 0;
  bit          err_seen = 0;
  int          cyc = 0, acc_cyc = 0, we_cyc = 0;
  int          n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  task automatic step(input bit v, input logic [1:0] op, input logic [3:0] rd,
                      input logic [15:0] imm, input bit fl, input bit rn);
    bit exp_ready, exp_we, exp_err;
    @(negedge clk);
    req_valid = v; req_op = op; req_rd = rd; req_imm = imm; flush = fl; rst_n = rn;
    #1;
    if (!rst_n) begin
      m_cnt = 0; m_err = 0; m_z = 0; m_s = 0;
    end
    exp_ready = !rst_n || (m_cnt == 0 && !m_err && !flush);
    exp_we    = rst_n && m_cnt == 1 && !flush;
    exp_err   = rst_n && m_err && !flush;
    check("req_ready", req_ready, exp_ready);
    check("rf_we", rf_we, exp_we);
    check("done", done, exp_we);
    check("err", err, exp_err);
    check("flag_z", flag_z, m_z);
    check("flag_s", flag_s, m_s);
    if (exp_we) begin
      check("rf_waddr", rf_waddr, m_addr);
      check("rf_wdata", rf_wdata, m_val);
    end
    if (ula_tipo == 2'b11) check("const_hi_zero", ula_constante[15:8], 0);
    if (rf_we) we_cyc = cyc;
    if (err) err_seen = 1;
    m_accepted = 0;
    if (rst_n) begin
      if (flush) begin
        m_cnt = 0; m_err = 0;
      end else if (m_cnt == 1) begin
        ref_mem[m_addr] = m_val;
        m_z = (m_val == 16'h0000);
        m_s = m_val[15];
        m_cnt = 0;
      end else if (m_cnt > 1) begin
        m_cnt--;
      end else if (m_err) begin
        m_err = 0;
      end else if (v) begin
        m_accepted = 1;
        acc_cyc = cyc;
        m_addr = rd;
        case (op)
          2'b01: begin m_cnt = 2; m_val = imm; end
          2'b10: begin m_cnt = 3; m_val = {ref_mem[rd][15:8], imm[7:0]}; end
          2'b11: begin m_cnt = 3; m_val = {imm[7:0], ref_mem[rd][7:0]}; end
          default: m_err = 1;
        endcase
      end
    end
    cyc++;
  endtask

  task automatic idle_step();
    step(0, 2'b00, 4'h0, 16'h0000, 0, 1);
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [3:0] rd, input logic [15:0] imm);
    int n = 0;
    do begin
      step(1, op, rd, imm, 0, 1);
      n++;
    end while (!m_accepted && n < 20);
    if (!m_accepted) bound_fail("accept_wait");
    n = 0;
    while ((m_cnt != 0 || m_err) && n < 20) begin
      idle_step();
      n++;
    end
    if (n >= 20) bound_fail("complete_wait");
    idle_step();
  endtask

  logic [1:0]  q_op  [3];
  logic [3:0]  q_rd  [3];
  logic [15:0] q_imm [3];

  initial begin
    int wc;
    int idx;
    int n;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem[5] = 16'hABCD;
    ref_mem[5] = 16'hABCD;

    step(0, 2'b00, 4'h0, 16'h0000, 0, 0);
    step(1, 2'b01, 4'h1, 16'h1111, 0, 0);
    check("reset_ready", req_ready, 1);
    check("reset_flag_z", flag_z, 0);
    idle_step();

    run_instr(2'b01, 4'd3, 16'h8001);
    check("ldl_latency", we_cyc - acc_cyc, 2);
    check("ldl_mem", mem[3], 16'h8001);
    check("ldl_ref", ref_mem[3], 16'h8001);
    check("ldl_flag_s", flag_s, 1);
    check("ldl_flag_z", flag_z, 0);

    run_instr(2'b10, 4'd5, 16'hFF12);
    check("lcl_latency", we_cyc - acc_cyc, 3);
    check("lcl_mem", mem[5], 16'hAB12);
    run_instr(2'b11, 4'd5, 16'h0034);
    check("lch_mem", mem[5], 16'h3412);
    check("lch_ref", ref_mem[5], 16'h3412);

    run_instr(2'b01, 4'd2, 16'h0000);
    check("zero_mem", mem[2], 16'h0000);
    check("zero_flag_z", flag_z, 1);

    wc = we_count;
    err_seen = 0;
    run_instr(2'b00, 4'd6, 16'h5555);
    check("ill_err_seen", err_seen, 1);
    check("ill_no_write", we_count, wc);
    check("ill_flag_z_kept", flag_z, 1);

    wc = we_count;
    step(1, 2'b11, 4'd4, 16'h0077, 0, 1);
    idle_step();
    idle_step();
    step(0, 2'b00, 4'h0, 16'h0000, 1, 1);
    idle_step();
    check("flush_ready", req_ready, 1);
    check("flush_no_write", we_count, wc);
    check("flush_mem", mem[4], 16'h0000);

    q_op[0] = 2'b01; q_rd[0] = 4'd7; q_imm[0] = 16'h1234;
    q_op[1] = 2'b10; q_rd[1] = 4'd7; q_imm[1] = 16'h0056;
    q_op[2] = 2'b11; q_rd[2] = 4'd7; q_imm[2] = 16'h009A;
    wc = we_count;
    idx = 0;
    n = 0;
    while ((idx < 3 || m_cnt != 0) && n < 40) begin
      if (idx < 3) step(1, q_op[idx], q_rd[idx], q_imm[idx], 0, 1);
      else idle_step();
      if (m_accepted) idx++;
      n++;
    end
    if (n >= 40) bound_fail("queue_wait");
    idle_step();
    check("queue_writes", we_count - wc, 3);
    check("queue_mem", mem[7], 16'h9A56);

    for (int i = 0; i < 3000; i++) begin
      bit v, fl, rn;
      v  = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 15) == 0);
      rn = ($urandom_range(0, 199) != 0);
      if (!rn) fl = 0;
      step(v, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom), fl, rn);
    end
    idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
